// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder: valid/ready on both ends plus flags.
interface pipelined_adder_if #(
  parameter int unsigned N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         C_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Y;
  logic         C_out;
  logic         V;
  logic         Z;

  modport master (
    output in_valid, A, B, C_in, sub, out_ready,
    input  in_ready, out_valid, Y, C_out, V, Z
  );

  modport slave (
    input  in_valid, A, B, C_in, sub, out_ready,
    output in_ready, out_valid, Y, C_out, V, Z
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: N bits split into STAGES slices, one slice per cycle, with flags.
// Define ADDER_SATURATE_EN to clamp Y to the signed extreme on overflow.
module pipelined_adder #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pipelined_adder_if.slave bus
);

  localparam int unsigned W = (STAGES == 0) ? 1 : N / STAGES;

  if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: STAGES must be in 1..N and divide N");
  end
  if ($bits(bus.A) != N) begin : g_bad_if
    $error("pipelined_adder: interface width does not match N");
  end

  logic         stall;
  logic [N-1:0] y_q;
  logic         cout_q, v_q, z_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0] a_d, bp_d, r_d, r_nx;
    logic         c_d, v_d, vld_q;
    logic [W:0]   sl;

    if (k == 0) begin : g_src
      assign a_d  = bus.A;
      assign bp_d = bus.sub ? ~bus.B : bus.B;
      assign r_d  = '0;
      assign c_d  = bus.sub | bus.C_in;
      assign v_d  = bus.in_valid;
    end else begin : g_src
      assign a_d  = g_stage[k-1].g_reg.a_q;
      assign bp_d = g_stage[k-1].g_reg.bp_q;
      assign r_d  = g_stage[k-1].g_reg.r_q;
      assign c_d  = g_stage[k-1].g_reg.c_q;
      assign v_d  = g_stage[k-1].vld_q;
    end

    assign sl = {1'b0, a_d[k*W +: W]} + {1'b0, bp_d[k*W +: W]} + {{W{1'b0}}, c_d};

    always_comb begin
      r_nx            = r_d;
      r_nx[k*W +: W]  = sl[W-1:0];
    end

    // The whole pipe advances together; bubbles are never squeezed out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (!stall) begin
        vld_q <= v_d;
      end
    end

    if (k < STAGES - 1) begin : g_reg
      logic [N-1:0] a_q, bp_q, r_q;
      logic         c_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bp_q <= '0;
          r_q  <= '0;
          c_q  <= 1'b0;
        end else if (!stall && v_d) begin
          a_q  <= a_d;
          bp_q <= bp_d;
          r_q  <= r_nx;
          c_q  <= sl[W];
        end
      end
    end else begin : g_last
      logic [N-1:0] y_fin;
      logic         v_fin;
      logic         unused_ops;

      assign v_fin = (a_d[N-1] == bp_d[N-1]) && (r_nx[N-1] != a_d[N-1]);
`ifdef ADDER_SATURATE_EN
      assign y_fin = !v_fin   ? r_nx :
                     a_d[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
      assign y_fin = r_nx;
`endif
      assign unused_ops = ^{a_d, bp_d};

      // Result and flags only move when a valid op lands, so they hold across bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q    <= '0;
          cout_q <= 1'b0;
          v_q    <= 1'b0;
          z_q    <= 1'b0;
        end else if (!stall && v_d) begin
          y_q    <= y_fin;
          cout_q <= sl[W];
          v_q    <= v_fin;
          z_q    <= (y_fin == '0);
        end
      end
    end
  end

  assign stall         = g_stage[STAGES-1].vld_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = g_stage[STAGES-1].vld_q;
  assign bus.Y         = y_q;
  assign bus.C_out     = cout_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: N=32/STAGES=4 main instance and N=8/STAGES=1 instance.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.N(32)) bus32 ();
  pipelined_adder_if #(.N(8))  bus8 ();

  pipelined_adder #(.N(32), .STAGES(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  pipelined_adder #(.N(8), .STAGES(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

`ifdef ADDER_SATURATE_EN
  localparam logic [31:0] T2Y = 32'h7FFF_FFFF;
  localparam logic [7:0]  T6Y = 8'h80;
  localparam logic        T6Z = 1'b0;
`else
  localparam logic [31:0] T2Y = 32'h8000_0000;
  localparam logic [7:0]  T6Y = 8'h00;
  localparam logic        T6Z = 1'b1;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op through an otherwise idle pipe; inputs are scribbled right after the transfer.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic s, input logic [31:0] ey,
                         input logic ec, input logic ev, input logic ez);
    tick();
    bus32.in_valid = 1'b1;
    bus32.A        = a;
    bus32.B        = b;
    bus32.C_in     = cin;
    bus32.sub      = s;
    tick();
    bus32.in_valid = 1'b0;
    bus32.A        = $urandom;
    bus32.B        = $urandom;
    bus32.C_in     = ~cin;
    bus32.sub      = ~s;
    repeat (2) tick();
    @(negedge clk);
    check({tag, " early"}, 64'(bus32.out_valid), 64'd0);
    tick();
    @(negedge clk);
    check({tag, " valid"}, 64'(bus32.out_valid), 64'd1);
    check({tag, " Y"},     64'(bus32.Y),         64'(ey));
    check({tag, " C_out"}, 64'(bus32.C_out),     64'(ec));
    check({tag, " V"},     64'(bus32.V),         64'(ev));
    check({tag, " Z"},     64'(bus32.Z),         64'(ez));
  endtask

  // 20 ops A=i, B=i<<8 -> Y=i*257; rnd toggles out_ready every cycle.
  task automatic stream(input bit rnd);
    int  in_i  = 0;
    int  out_i = 0;
    int  cyc   = 0;
    int  first = -1;
    int  last  = -1;
    bit  in_acc, out_acc;
    tick();
    bus32.out_ready = 1'b1;
    bus32.in_valid  = 1'b1;
    bus32.A         = 32'd0;
    bus32.B         = 32'd0;
    bus32.C_in      = 1'b0;
    bus32.sub       = 1'b0;
    while (out_i < 20 && cyc < 400) begin
      @(negedge clk);
      in_acc  = bus32.in_valid && bus32.in_ready;
      out_acc = bus32.out_valid && bus32.out_ready;
      check("in_ready rule", 64'(bus32.in_ready), 64'(!(bus32.out_valid && !bus32.out_ready)));
      if (out_acc) begin
        check($sformatf("stream Y[%0d]", out_i), 64'(bus32.Y), 64'(out_i * 257));
        check($sformatf("stream Z[%0d]", out_i), 64'(bus32.Z), 64'(out_i == 0));
        if (first < 0) first = cyc;
        last = cyc;
        out_i++;
      end
      tick();
      if (in_acc) in_i++;
      if (in_i < 20) begin
        bus32.in_valid = 1'b1;
        bus32.A        = 32'(in_i);
        bus32.B        = 32'(in_i) << 8;
      end else begin
        bus32.in_valid = 1'b0;
      end
      bus32.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    check("stream count", 64'(out_i), 64'd20);
    if (!rnd) begin
      check("stream first latency", 64'(first), 64'd4);
      check("stream last cycle",    64'(last),  64'd23);
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("stream drained", 64'(bus32.out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus32.in_valid = 1'b0; bus32.A = '0; bus32.B = '0; bus32.C_in = 1'b0; bus32.sub = 1'b0;
    bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.C_in = 1'b0; bus8.sub = 1'b0;
    bus8.out_ready = 1'b1;

    @(negedge clk);
    check("reset out_valid", 64'(bus32.out_valid), 64'd0);
    check("reset in_ready",  64'(bus32.in_ready),  64'd1);
    check("reset Y",         64'(bus32.Y),         64'd0);
    check("reset flags",     64'({bus32.C_out, bus32.V, bus32.Z}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("carry ripple", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("pos overflow", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, T2Y,           1'b0, 1'b1, 1'b0);
    run_one("sub borrow",   32'd5,         32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub equal",    32'd7,         32'd7, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("add c_in",     32'h0000_FFFF, 32'h0001_0000, 1'b1, 1'b0,
            32'h0002_0000, 1'b0, 1'b0, 1'b0);
    run_one("neg overflow", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
`ifdef ADDER_SATURATE_EN
            32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
            32'h0000_0000, 1'b1, 1'b1, 1'b1);
`endif

    stream(1'b0);
    stream(1'b1);

    // Fill the pipe while the consumer stalls, then reset mid-cycle.
    tick();
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus32.in_valid = 1'b1;
      bus32.A        = 32'h100 + 32'(i);
      bus32.B        = 32'h10;
      bus32.C_in     = 1'b0;
      bus32.sub      = 1'b0;
      tick();
    end
    bus32.in_valid = 1'b0;
    @(negedge clk);
    check("full out_valid", 64'(bus32.out_valid), 64'd1);
    check("full in_ready",  64'(bus32.in_ready),  64'd0);
    check("full Y",         64'(bus32.Y),         64'h110);
    repeat (2) tick();
    @(negedge clk);
    check("stall hold Y",   64'(bus32.Y),         64'h110);
    #2;
    rst_n = 1'b0;
    #1;
    check("flush out_valid", 64'(bus32.out_valid), 64'd0);
    check("flush Y",         64'(bus32.Y),         64'd0);
    bus32.out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus32.out_valid) seen = 1'b1;
    end
    check("no stale result", 64'(seen), 64'd0);

    // Single-stage 8-bit instance: latency of one register.
    tick();
    bus8.in_valid = 1'b1;
    bus8.A        = 8'h80;
    bus8.B        = 8'h80;
    @(negedge clk);
    check("n8 early", 64'(bus8.out_valid), 64'd0);
    tick();
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("n8 valid", 64'(bus8.out_valid), 64'd1);
    check("n8 Y",     64'(bus8.Y),         64'(T6Y));
    check("n8 C_out", 64'(bus8.C_out),     64'd1);
    check("n8 V",     64'(bus8.V),         64'd1);
    check("n8 Z",     64'(bus8.Z),         64'(T6Z));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
